// File: rtl/ddr5_refresh_credit_sched.sv
// DDR5 refresh credit scheduler: per-rank refresh interval counters build up debt,
// and a two-level round-robin arbiter offers all-bank or same-bank refreshes to the scheduler.

module ddr5_refresh_rank #(
  parameter int NUM_RANKS    = 2,
  parameter int RANK         = 0,
  parameter int T_REFI       = 7800,
  parameter int T_RFC_AB     = 350,
  parameter int T_RFC_SB     = 120,
  parameter int MAX_POSTPONE = 4,
  parameter int CW           = 13,
  parameter int BW           = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fgr,
  input  logic              hs,
  input  logic              sb,
  input  logic              clr_bank,
  output logic signed [3:0] debt,
  output logic              busy,
  output logic [1:0]        bank,
  output logic              ovf
);
  localparam logic [CW-1:0]     PER_1X   = CW'(T_REFI);
  localparam logic [CW-1:0]     PER_2X   = CW'(T_REFI / 2);
  localparam logic [CW-1:0]     OFF_1X   = CW'(RANK * (T_REFI / NUM_RANKS));
  localparam logic [CW-1:0]     OFF_2X   = CW'(RANK * ((T_REFI / 2) / NUM_RANKS));
  localparam logic signed [3:0] DEBT_MAX = 4'(MAX_POSTPONE + 1);

  logic [CW-1:0] cnt, per, off;
  logic [BW-1:0] tmr;
  logic          tick, dec;

  assign per  = fgr ? PER_2X : PER_1X;
  assign off  = fgr ? OFF_2X : OFF_1X;
  // >= rather than == so a shrink of the period mid-count still ticks
  assign tick = en && (cnt >= per - CW'(1));
  assign dec  = hs && (!sb || bank == 2'd3);
  assign ovf  = tick && !dec && (debt == DEBT_MAX);
  assign busy = |tmr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= OFF_1X;
      debt <= '0;
      tmr  <= '0;
      bank <= '0;
    end else begin
      if (!en)       cnt <= off;
      else if (tick) cnt <= '0;
      else           cnt <= cnt + CW'(1);

      if (tick && !dec && debt != DEBT_MAX) debt <= debt + 4'sd1;
      else if (!tick && dec)                debt <= debt - 4'sd1;

      if (hs)        tmr <= sb ? BW'(T_RFC_SB) : BW'(T_RFC_AB);
      else if (busy) tmr <= tmr - BW'(1);

      if (clr_bank)      bank <= '0;
      else if (hs && sb) bank <= bank + 2'd1;
    end
  end
endmodule

module ddr5_refresh_credit_sched #(
  parameter int NUM_RANKS    = 2,
  parameter int T_REFI       = 7800,
  parameter int T_RFC_AB     = 350,
  parameter int T_RFC_SB     = 120,
  parameter int MAX_POSTPONE = 4,
  parameter int MAX_PULLIN   = 4,
  localparam int RW          = (NUM_RANKS > 1) ? $clog2(NUM_RANKS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_en_refresh,
  input  logic                   cfg_fgr_2x,
  input  logic                   cfg_sb_mode,
  input  logic [NUM_RANKS-1:0]   idle_hint,
  output logic                   ref_req_valid,
  input  logic                   ref_req_ready,
  output logic [RW-1:0]          ref_req_rank,
  output logic                   ref_req_type,
  output logic [1:0]             ref_req_bank,
  output logic                   ref_req_urgent,
  output logic [NUM_RANKS-1:0]   rank_busy,
  output logic [4*NUM_RANKS-1:0] ref_debt,
  output logic                   ref_overflow_err
);
  localparam int CW = $clog2(T_REFI + 1);
  localparam int BW = $clog2(((T_RFC_AB > T_RFC_SB) ? T_RFC_AB : T_RFC_SB) + 1);

  typedef enum logic {IDLE, OFFER} state_t;
  state_t state;

  logic [NUM_RANKS-1:0] busy_v, ovf_v, elig, urg, hs_v;
  logic signed [3:0]    dbt [NUM_RANKS];
  logic [1:0]           bnk [NUM_RANKS];
  logic [RW-1:0]        ptr, win, k;
  logic                 win_ok, hs, start, sb_q, fgr_q, clr_bank;

  assign ref_req_valid  = (state == OFFER);
  assign hs             = ref_req_valid && ref_req_ready;
  assign ref_req_urgent = ref_req_valid && urg[ref_req_rank];
  assign rank_busy      = busy_v;
  assign start          = (state == IDLE) && cfg_en_refresh && win_ok;
  assign clr_bank       = start && (cfg_sb_mode != sb_q);

  for (genvar r = 0; r < NUM_RANKS; r++) begin : g_rank
    assign hs_v[r] = hs && (ref_req_rank == RW'(r));
    assign urg[r]  = int'(dbt[r]) >= MAX_POSTPONE;
    assign elig[r] = !busy_v[r] && !(ref_req_valid && ref_req_rank == RW'(r)) &&
                     (int'(dbt[r]) > 0 || (idle_hint[r] && int'(dbt[r]) > -MAX_PULLIN));
    assign ref_debt[4*r +: 4] = dbt[r];

    ddr5_refresh_rank #(
      .NUM_RANKS(NUM_RANKS), .RANK(r), .T_REFI(T_REFI), .T_RFC_AB(T_RFC_AB),
      .T_RFC_SB(T_RFC_SB), .MAX_POSTPONE(MAX_POSTPONE), .CW(CW), .BW(BW)
    ) u_rank (
      .clk(clk), .rst(rst), .en(cfg_en_refresh), .fgr(fgr_q), .hs(hs_v[r]),
      .sb(ref_req_type), .clr_bank(clr_bank), .debt(dbt[r]), .busy(busy_v[r]),
      .bank(bnk[r]), .ovf(ovf_v[r])
    );
  end

  // Urgent pass first, then any eligible rank; both rotate from the rank after the last grant.
  always_comb begin
    win    = '0;
    win_ok = 1'b0;
    k      = '0;
    for (int i = 1; i <= NUM_RANKS; i++) begin
      k = RW'((int'(ptr) + i) % NUM_RANKS);
      if (!win_ok && elig[k] && urg[k]) begin
        win    = k;
        win_ok = 1'b1;
      end
    end
    for (int i = 1; i <= NUM_RANKS; i++) begin
      k = RW'((int'(ptr) + i) % NUM_RANKS);
      if (!win_ok && elig[k]) begin
        win    = k;
        win_ok = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      ref_req_rank     <= '0;
      ref_req_type     <= 1'b0;
      ref_req_bank     <= '0;
      ptr              <= '0;
      sb_q             <= 1'b0;
      fgr_q            <= 1'b0;
      ref_overflow_err <= 1'b0;
    end else begin
      if (|ovf_v) ref_overflow_err <= 1'b1;
      case (state)
        IDLE: if (start) begin
          state        <= OFFER;
          ref_req_rank <= win;
          ref_req_type <= cfg_sb_mode;
          // a same-bank mode switch restarts every rank at bank 0
          ref_req_bank <= (cfg_sb_mode && sb_q) ? bnk[win] : 2'd0;
          ptr          <= win;
          sb_q         <= cfg_sb_mode;
          fgr_q        <= cfg_fgr_2x;
        end
        OFFER: if (ref_req_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ddr5_refresh_credit_sched.sv
// Randomized bench for ddr5_refresh_credit_sched: a reference model predicts offers into a
// scoreboard queue that a separate monitor drains; per-cycle state is checked as well.
module tb_ddr5_refresh_credit_sched;
  localparam int N = 2, TR = 100, RAB = 20, RSB = 8, MP = 4, MPI = 4;

  logic           clk = 1'b0;
  logic           rst, en, fgr, sb, ready;
  logic [N-1:0]   idle;
  logic           valid, rtype, urgent, err;
  logic [0:0]     rrank;
  logic [1:0]     rbank;
  logic [N-1:0]   busy;
  logic [4*N-1:0] debt;

  always #5 clk = ~clk;

  ddr5_refresh_credit_sched #(
    .NUM_RANKS(N), .T_REFI(TR), .T_RFC_AB(RAB), .T_RFC_SB(RSB),
    .MAX_POSTPONE(MP), .MAX_PULLIN(MPI)
  ) dut (
    .clk(clk), .rst(rst), .cfg_en_refresh(en), .cfg_fgr_2x(fgr), .cfg_sb_mode(sb),
    .idle_hint(idle), .ref_req_valid(valid), .ref_req_ready(ready), .ref_req_rank(rrank),
    .ref_req_type(rtype), .ref_req_bank(rbank), .ref_req_urgent(urgent),
    .rank_busy(busy), .ref_debt(debt), .ref_overflow_err(err)
  );

  typedef struct { int rank; int typ; int bank; } offer_t;
  offer_t exp_q[$];

  int total = 0, bad = 0, cyc = 0, ph = 0;

  // reference model state: what the DUT should show in the current cycle
  int m_cnt[N], m_debt[N], m_busy[N], m_bank[N];
  int m_ptr, m_rank, m_type, m_bankout;
  bit m_off, m_sb, m_fgr, m_err;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < N; r++) begin
      m_cnt[r] = r * (TR / N); m_debt[r] = 0; m_busy[r] = 0; m_bank[r] = 0;
    end
    m_ptr = 0; m_rank = 0; m_type = 0; m_bankout = 0;
    m_off = 0; m_sb = 0; m_fgr = 0; m_err = 0;
    exp_q.delete();
  endtask

  function automatic bit m_elig(input int r);
    return m_busy[r] == 0 && !(m_off && m_rank == r) &&
           (m_debt[r] > 0 || (idle[r] && m_debt[r] > -MPI));
  endfunction

  function automatic int m_pick();
    int best = -1;
    for (int pass = 0; pass < 2; pass++)
      for (int i = 1; i <= N; i++) begin
        int r = (m_ptr + i) % N;
        if (best < 0 && m_elig(r) && (pass == 1 || m_debt[r] >= MP)) best = r;
      end
    return best;
  endfunction

  // advance the model across one clock edge with the inputs now applied
  task automatic model_step();
    int p, best;
    bit hs, tk, dc;
    p    = m_fgr ? TR / 2 : TR;
    hs   = m_off && ready;
    best = (!m_off && en) ? m_pick() : -1;
    for (int r = 0; r < N; r++) begin
      tk = en && (m_cnt[r] >= p - 1);
      dc = hs && m_rank == r && (m_type == 0 || m_bank[r] == 3);
      if (tk && !dc) begin
        if (m_debt[r] == MP + 1) m_err = 1; else m_debt[r]++;
      end else if (dc && !tk) m_debt[r]--;
      if (hs && m_rank == r) begin
        m_busy[r] = m_type ? RSB : RAB;
        if (m_type == 1) m_bank[r] = (m_bank[r] + 1) % 4;
      end else if (m_busy[r] > 0) m_busy[r]--;
      m_cnt[r] = !en ? r * (p / N) : (tk ? 0 : m_cnt[r] + 1);
    end
    if (m_off) begin
      if (hs) m_off = 0;
    end else if (best >= 0) begin
      if (sb != m_sb) for (int r = 0; r < N; r++) m_bank[r] = 0;
      m_off = 1; m_rank = best; m_type = int'(sb);
      m_bankout = sb ? m_bank[best] : 0;
      m_sb = sb; m_fgr = fgr; m_ptr = best;
      exp_q.push_back('{best, int'(sb), m_bankout});
    end
  endtask

  task automatic compare_all();
    logic [4*N-1:0] pk;
    logic [N-1:0]   bv;
    int             dv;
    for (int r = 0; r < N; r++) begin
      dv = m_debt[r];
      pk[4*r +: 4] = dv[3:0];
      bv[r] = m_busy[r] > 0;
    end
    check("valid", int'(valid), int'(m_off));
    check("urgent", int'(urgent), int'(m_off && m_debt[m_rank] >= MP));
    check("busy", int'(busy), int'(bv));
    check("debt", int'(debt), int'(pk));
    check("overflow_err", int'(err), int'(m_err));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_valid", int'(valid), 0);
    check("rst_debt", int'(debt), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_err", int'(err), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    compare_all();
  endtask

  task automatic directed();
    if (ph == 1) begin
      if (cyc == 50)  check("p1_valid_c50", int'(valid), 0);
      if (cyc == 51)  begin check("p1_valid_c51", int'(valid), 1); check("p1_rank_c51", int'(rrank), 1); end
      if (cyc == 101) begin check("p1_valid_c101", int'(valid), 1); check("p1_rank_c101", int'(rrank), 0); end
      if (cyc == 51)  check("p1_busy1_c51", int'(busy[1]), 0);
      if (cyc == 52)  check("p1_busy1_c52", int'(busy[1]), 1);
      if (cyc == 71)  check("p1_busy1_c71", int'(busy[1]), 1);
      if (cyc == 72)  check("p1_busy1_c72", int'(busy[1]), 0);
    end
    if (ph == 4) begin
      if (cyc == 101) check("p4_bank_c101", int'(rbank), 0);
      if (cyc == 111) check("p4_bank_c111", int'(rbank), 1);
      if (cyc == 109) check("p4_busy0_c109", int'(busy[0]), 1);
      if (cyc == 110) check("p4_busy0_c110", int'(busy[0]), 0);
      if (cyc == 131) begin
        check("p4_bank_c131", int'(rbank), 3);
        check("p4_debt0_c131", int'($signed(debt[3:0])), 1);
      end
      if (cyc == 132) check("p4_debt0_c132", int'($signed(debt[3:0])), 0);
    end
    if (ph == 5 && cyc == 90) begin
      check("p5_debt0_floor", int'($signed(debt[3:0])), -4);
      check("p5_no_offer", int'(valid), 0);
    end
  endtask

  task automatic randomize_inputs();
    if (en) begin if ($urandom_range(199) == 0) en = 1'b0; end
    else if ($urandom_range(19) == 0) en = 1'b1;
    if ($urandom_range(299) == 0) fgr = ~fgr;
    if ($urandom_range(149) == 0) sb = ~sb;
    idle  = N'($urandom);
    ready = ($urandom_range(3) != 0);
  endtask

  task automatic run(input int n, input bit rnd);
    for (int c = 0; c < n; c++) begin
      if (rnd) begin
        randomize_inputs();
        if ($urandom_range(1499) == 0) do_reset();
      end
      model_step();
      @(negedge clk);
      cyc++;
      compare_all();
      directed();
    end
  endtask

  // monitor: each new offer is popped from the scoreboard and its fields compared
  initial begin
    bit pv;
    offer_t e;
    pv = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) pv = 0;
      else begin
        if (valid && !pv) begin
          check("offer_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("offer_rank", int'(rrank), e.rank);
            check("offer_type", int'(rtype), e.typ);
            check("offer_bank", int'(rbank), e.bank);
          end
        end
        pv = valid;
      end
    end
  end

  initial begin
    rst = 1'b0; en = 1'b1; fgr = 1'b0; sb = 1'b0; idle = '0; ready = 1'b1;
    @(negedge clk);
    ph = 1; do_reset(); run(120, 0);

    ph = 2; ready = 1'b0; run(600, 0);
    check("p2_debt0", int'($signed(debt[3:0])), 5);
    check("p2_debt1", int'($signed(debt[7:4])), 5);
    check("p2_overflow", int'(err), 1);
    check("p2_urgent", int'(urgent), 1);

    ph = 3; do_reset(); ready = 1'b1; run(60, 0);

    ph = 4; sb = 1'b1; do_reset(); run(200, 0);

    ph = 5; sb = 1'b0; idle = 2'b01; do_reset(); run(100, 0);

    ph = 6; idle = '0; run(3000, 1);

    en = 1'b0; ready = 1'b1; run(4, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ddr5_refresh_credit_sched.md
DDR5_REFRESH_CREDIT_SCHED -- requirements
Module: ddr5_refresh_credit_sched

Interface
REQ-001 SHALL have parameter NUM_RANKS, default 2, meaning number of ranks (1..8).
REQ-002 SHALL have parameter T_REFI, default 7800, meaning the 1x refresh interval in clk cycles (even, >= 2*NUM_RANKS).
REQ-003 SHALL have parameter T_RFC_AB, default 350, meaning the all-bank refresh busy time in cycles.
REQ-004 SHALL have parameter T_RFC_SB, default 120, meaning the same-bank refresh busy time in cycles.
REQ-005 SHALL have parameter MAX_POSTPONE, default 4, meaning the debt level at which a rank becomes urgent (1..6).
REQ-006 SHALL have parameter MAX_PULLIN, default 4, meaning the maximum refreshes issued ahead of schedule (0..8).
REQ-007 SHALL use RW = max(1, $clog2(NUM_RANKS)).
REQ-008 clk  in  1  sole clock, all state on rising edge.
REQ-009 rst  in  1  asynchronous, active-high reset.
REQ-010 cfg_en_refresh  in  1  refresh engine enable.
REQ-011 cfg_fgr_2x  in  1  fine-granularity mode 2x: interval = T_REFI/2.
REQ-012 cfg_sb_mode  in  1  issue same-bank refreshes instead of all-bank refreshes.
REQ-013 idle_hint  in  NUM_RANKS  per-rank scheduler-idle flag that enables pull-in.
REQ-014 ref_req_valid  out  1  refresh request offered.
REQ-015 ref_req_ready  in  1  scheduler accepts the request.
REQ-016 ref_req_rank  out  RW  target rank.
REQ-017 ref_req_type  out  1  0 = all-bank, 1 = same-bank.
REQ-018 ref_req_bank  out  2  bank-in-BG index for same-bank; 0 for all-bank.
REQ-019 ref_req_urgent  out  1  target rank debt >= MAX_POSTPONE.
REQ-020 rank_busy  out  NUM_RANKS  rank inside tRFC window.
REQ-021 ref_debt  out  4*NUM_RANKS  per-rank signed two's-complement debt, rank r at [4r+:4].
REQ-022 ref_overflow_err  out  1  sticky flag: debt would have exceeded MAX_POSTPONE+1.

Function
REQ-023 Each rank SHALL have its own interval counter with period P = T_REFI (1x) or T_REFI/2 (2x); the counter reloads to stagger offset r*(P/NUM_RANKS).
REQ-024 The rank SHALL generate a tick in the cycle where its counter >= P-1, and the counter SHALL wrap to 0 on the next edge; a mode change mid-count takes effect through the >= compare, with no reset of the counter.
REQ-025 A tick SHALL increment debt by 1; when debt is already MAX_POSTPONE+1, debt SHALL hold and ref_overflow_err SHALL set.
REQ-026 A rank SHALL be eligible when !rank_busy, is not currently offered, and either (a) debt > 0, or (b) idle_hint[r] = 1 and debt > -MAX_PULLIN.
REQ-027 Arbitration SHALL pick urgent eligible ranks first, then the remaining eligible ranks, each round-robin starting from the rank after the last granted rank (pointer resets to 0).
REQ-028 Offer states SHALL be IDLE and OFFER: IDLE -> OFFER registers the winner one cycle after eligibility; OFFER -> IDLE on valid && ready.
REQ-029 While in OFFER, rank/type/bank SHALL be stable; urgent SHALL be recomputed from live debt.
REQ-030 A handshake in all-bank mode SHALL decrement the rank's debt by 1 and set rank_busy for exactly T_RFC_AB cycles, starting the next cycle.
REQ-031 In same-bank mode each handshake SHALL set busy for T_RFC_SB cycles and advance the rank's bank index 0->1->2->3->0; debt SHALL decrement only on the 3->0 handshake.
REQ-032 A tick and a debt-decrementing handshake in the same cycle on one rank SHALL leave debt unchanged.
REQ-033 The mode inputs cfg_sb_mode and cfg_fgr_2x SHALL be sampled at the IDLE -> OFFER transition; a cfg_sb_mode change SHALL reset all bank indices to 0.
REQ-034 With cfg_en_refresh = 0: counters SHALL hold at their stagger offset, debt SHALL hold, no new offers SHALL be made, a pending offer SHALL stay until its handshake, and busy timers SHALL run out.

Reset
REQ-035 Reset SHALL clear, immediately and also mid-offer: ref_req_valid = 0, rank = 0, type = 0, bank = 0, urgent = 0, rank_busy = 0, all debts = 0, bank indices = 0, RR pointer = 0, ref_overflow_err = 0, and counters = stagger offsets.

Verification (NUM_RANKS=2, T_REFI=100, T_RFC_AB=20, T_RFC_SB=8, MAX_POSTPONE=4, MAX_PULLIN=4, ready=1, idle_hint=0)
REQ-036 Release reset at cycle 0 -> rank1 ticks at cycle 49 and rank0 at cycle 99; valid rises at cycles 51 (rank1) and 101 (rank0); rank_busy[1] is high for cycles 52-71.
REQ-037 Hold ready=0 for 500 cycles -> debt0 reaches 4 and urgent=1; at debt 5 the next tick sets ref_overflow_err, and debt stays 5.
REQ-038 Set cfg_sb_mode=1 -> rank0 issues banks 0, 1, 2, 3 with 8-cycle busy gaps; debt0 drops by 1 only after bank 3 is accepted.
REQ-039 Set idle_hint=2'b01 with debt0=0 -> rank0 issues pull-ins until debt0 = -4, then no further offers until the next tick.
REQ-040 Assert rst during OFFER with debt0=3 -> valid=0 and debt=0 in the same cycle; after release the sequence restarts as in REQ-036.
